// File: rtl/p2s_pkg.sv
// rtl/p2s_pkg.sv - shared types and helpers for the p2s_tx transmitter
//
// Purpose: FSM state type, legal-width check and output-bit selection
// shared by the p2s_tx files.
// Ports: none (package).
package p2s_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Widest word the bit-selection helper can carry.
  localparam int MAX_W  = 64;
  localparam int MAX_AW = $clog2(MAX_W);

  // A word needs at least two bits so the first and last strobes never overlap.
  function automatic bit width_ok(input int w);
    return (w >= 2) && (w <= MAX_W);
  endfunction

  // Bit presented by a w-bit shift register: the top end when shifting left
  // (MSB first), the bottom end when shifting right (LSB first).
  function automatic logic out_bit(input logic [MAX_W-1:0] v, input int w,
                                   input bit msb_first);
    return msb_first ? v[MAX_AW'(w - 1)] : v[0];
  endfunction

endpackage

// File: rtl/p2s_tx_if.sv
// rtl/p2s_tx_if.sv - parallel word input and serial output bundle of p2s_tx
//
// Purpose: groups the word handshake and the serial/framing outputs.
// Ports (signals):
//   pin[W-1:0]  word to transmit            (producer -> transmitter)
//   pin_valid   pin holds a word            (producer -> transmitter)
//   pin_ready   holding register empty      (transmitter -> producer)
//   sout        serial data bit             (transmitter -> line)
//   sfirst      first bit of a word         (transmitter -> line)
//   slast       last bit of a word          (transmitter -> line)
//   busy        shifter is transmitting     (transmitter -> line)
// Modports: master = producer/observer side, slave = transmitter side.
interface p2s_tx_if #(
  parameter int W = 4
) ();

  logic [W-1:0] pin;
  logic         pin_valid;
  logic         pin_ready;
  logic         sout;
  logic         sfirst;
  logic         slast;
  logic         busy;

  modport master (
    output pin, pin_valid,
    input  pin_ready, sout, sfirst, slast, busy
  );

  modport slave (
    input  pin, pin_valid,
    output pin_ready, sout, sfirst, slast, busy
  );

endinterface

// File: rtl/p2s_tx.sv
// rtl/p2s_tx.sv - parallel-to-serial transmitter with one-word holding register
//
// Purpose: accepts W-bit words over a valid/ready handshake and shifts them
// out one bit per clock, with first/last framing strobes. A holding register
// lets the next word be taken while the current one shifts, so back-to-back
// words stream with no idle bit.
// Ports:
//   clk  input  system clock, rising edge
//   rst  input  synchronous active-high reset
//   bus  p2s_tx_if.slave  word handshake in, serial line and framing out
module p2s_tx
  import p2s_pkg::*;
#(
  parameter  int W         = 4,
  parameter  bit MSB_FIRST = 1'b1,
  localparam int CW        = $clog2(W)
) (
  input  logic     clk,
  input  logic     rst,
  p2s_tx_if.slave  bus
);

  if (!width_ok(W)) begin : g_bad_width
    $error("p2s_tx: W must lie in 2..64");
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [W-1:0]  hbuf_q, hbuf_d;
  logic          hvalid_q, hvalid_d;

  logic accept;
  logic load;
  logic last_bit;
  logic shifting;

  // Ready depends only on the holding register, never on pin_valid.
  assign accept   = bus.pin_valid && !hvalid_q;
  assign last_bit = (cnt_q == CW'(W - 1));
  assign shifting = (state_q == SHIFT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      hbuf_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      hbuf_q   <= hbuf_d;
      hvalid_q <= hvalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    hbuf_d   = hbuf_q;
    hvalid_d = hvalid_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hvalid_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Reloading straight from the holding register keeps the line gap-free.
          if (hvalid_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        end
      end
    endcase

    // Accept needs an empty holding register and load needs a full one, so the
    // two can never fire on the same edge.
    if (load) begin
      shreg_d  = hbuf_q;
      hvalid_d = 1'b0;
      cnt_d    = '0;
    end else if (accept) begin
      hbuf_d   = bus.pin;
      hvalid_d = 1'b1;
    end
  end

  assign bus.pin_ready = !hvalid_q;
  assign bus.busy      = shifting;
  assign bus.sout      = shifting && out_bit(MAX_W'(shreg_q), W, MSB_FIRST);
  assign bus.sfirst    = shifting && (cnt_q == '0);
  assign bus.slast     = shifting && last_bit;

endmodule
